// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter: instruction fetch and data load/store share
// one memory port, with one transaction outstanding and a data-streak fairness limit.
module mem_port_arbiter #(
  parameter int unsigned FAIR_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = 4;
  localparam int unsigned SW = $clog2(FAIR_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

  state_t          r_state, w_state_n;
  logic            r_owner, w_owner_n;   // 1 = data, 0 = inst
  logic            r_we, w_we_n;
  logic [BW-1:0]   r_be, w_be_n;
  logic [AW-1:0]   r_addr, w_addr_n;
  logic [DW-1:0]   r_wdata, w_wdata_n;
  logic [DW-1:0]   r_rdata, w_rdata_n;
  logic [SW-1:0]   r_streak, w_streak_n;
  logic            w_pick_data;
  logic            w_in_req;
  logic            w_in_done;

  // Next-state, arbitration and payload capture
  always_comb begin
    w_state_n   = r_state;
    w_owner_n   = r_owner;
    w_we_n      = r_we;
    w_be_n      = r_be;
    w_addr_n    = r_addr;
    w_wdata_n   = r_wdata;
    w_rdata_n   = r_rdata;
    w_streak_n  = r_streak;
    w_pick_data = data_req && !(inst_req && (r_streak == SW'(FAIR_LIMIT)));

    case (r_state)
      S_IDLE: begin
        if (inst_req || data_req) begin
          w_state_n = S_REQ;
          w_owner_n = w_pick_data;
          if (w_pick_data) begin
            w_we_n    = data_we;
            w_be_n    = data_be;
            w_addr_n  = data_addr;
            w_wdata_n = data_wdata;
            if (!inst_req)
              w_streak_n = '0;
            else if (r_streak != SW'(FAIR_LIMIT))
              w_streak_n = SW'(r_streak + SW'(1));
          end else begin
            w_we_n     = 1'b0;
            w_be_n     = {BW{1'b1}};
            w_addr_n   = inst_addr;
            w_wdata_n  = '0;
            w_streak_n = '0;
          end
        end
      end
      S_REQ: begin
        if (mem_gnt) w_state_n = S_RESP;
      end
      S_RESP: begin
        if (mem_rvalid) begin
          w_state_n = S_DONE;
          w_rdata_n = mem_rdata;
        end
      end
      S_DONE:  w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  assign w_in_req  = (w_state_n == S_REQ);
  assign w_in_done = (w_state_n == S_DONE);

  // State, latched payload and registered outputs (decoded from next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_streak   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_ack   <= 1'b0;
      data_ack   <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
      busy       <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_owner    <= w_owner_n;
      r_we       <= w_we_n;
      r_be       <= w_be_n;
      r_addr     <= w_addr_n;
      r_wdata    <= w_wdata_n;
      r_rdata    <= w_rdata_n;
      r_streak   <= w_streak_n;
      mem_req    <= w_in_req;
      mem_we     <= w_in_req & w_we_n;
      mem_be     <= w_in_req ? w_be_n    : '0;
      mem_addr   <= w_in_req ? w_addr_n  : '0;
      mem_wdata  <= w_in_req ? w_wdata_n : '0;
      inst_ack   <= w_in_done & ~w_owner_n;
      data_ack   <= w_in_done &  w_owner_n;
      if (w_in_done && !w_owner_n) inst_rdata <= w_rdata_n;
      if (w_in_done &&  w_owner_n) data_rdata <= w_rdata_n;
      busy       <= (w_state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, store, simultaneous requests,
// fairness ordering, spurious responses and reset in the middle of a transaction.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic [31:0] inst_rdata;
  logic        inst_ack;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_be;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        busy;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.FAIR_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ack(inst_ack),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_ack(data_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Memory responder: wait for mem_req, hold gnt low wait_cyc cycles, then gnt, then rvalid.
  // Returns at the negedge where the owner's ack should be visible.
  task automatic serve(input int wait_cyc, input logic spur, input logic [31:0] exp_addr,
                       input logic [31:0] exp_wdata, input logic [31:0] rd);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_seen", 32'(mem_req), 32'd1);
    check("mem_addr", mem_addr, exp_addr);
    for (int i = 0; i < wait_cyc; i++) begin
      mem_rvalid = spur;
      @(negedge clk);
      check("hold_req", 32'(mem_req), 32'd1);
      check("hold_addr", mem_addr, exp_addr);
      check("hold_wdata", mem_wdata, exp_wdata);
      check("hold_no_ack", 32'({inst_ack, data_ack}), 32'd0);
    end
    mem_rvalid = 1'b0;
    mem_gnt    = 1'b1;
    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = rd;
    check("resp_req_low", 32'(mem_req), 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_acks", 32'({inst_ack, data_ack}), 32'd0);
    check("rst_inst_rdata", inst_rdata, 32'd0);
    check("rst_data_rdata", data_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Spurious rvalid in IDLE
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("idle_spur_busy", 32'(busy), 32'd0);
    check("idle_spur_acks", 32'({inst_ack, data_ack}), 32'd0);
    check("idle_spur_rdata", inst_rdata, 32'd0);

    // Single fetch, gnt after 2 cycles with spurious rvalid in REQ
    inst_req = 1'b1; inst_addr = 32'hBFC00000;
    @(negedge clk);
    check("fetch_req_t1", 32'(mem_req), 32'd1);
    check("fetch_be", 32'(mem_be), 32'hF);
    check("fetch_we", 32'(mem_we), 32'd0);
    check("fetch_busy", 32'(busy), 32'd1);
    inst_addr = 32'h00000000;
    serve(2, 1'b1, 32'hBFC00000, 32'd0, 32'h3C08BFC0);
    check("fetch_ack", 32'(inst_ack), 32'd1);
    check("fetch_rdata", inst_rdata, 32'h3C08BFC0);
    check("fetch_no_dack", 32'(data_ack), 32'd0);
    inst_req = 1'b0;
    @(negedge clk);
    check("fetch_ack_pulse", 32'(inst_ack), 32'd0);
    check("fetch_idle", 32'(busy), 32'd0);
    check("fetch_rdata_hold", inst_rdata, 32'h3C08BFC0);

    // Store held through 3 cycles of gnt=0; requester-side payload change ignored
    data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
    data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("store_we", 32'(mem_we), 32'd1);
    check("store_be", 32'(mem_be), 32'h3);
    check("store_wdata", mem_wdata, 32'hDEADBEEF);
    data_wdata = 32'h12345678;
    serve(3, 1'b0, 32'h80001000, 32'hDEADBEEF, 32'h00000000);
    check("store_ack", 32'(data_ack), 32'd1);
    check("store_no_iack", 32'(inst_ack), 32'd0);
    data_req = 1'b0; data_we = 1'b0;
    @(negedge clk);
    check("store_ack_pulse", 32'(data_ack), 32'd0);
    check("store_inst_rdata_hold", inst_rdata, 32'h3C08BFC0);

    // Simultaneous requests: data first, inst at next IDLE
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h80002000; data_wdata = '0;
    inst_req = 1'b1; inst_addr = 32'hBFC00004;
    @(negedge clk);
    serve(0, 1'b0, 32'h80002000, 32'd0, 32'hCAFEF00D);
    check("sim_data_ack", 32'(data_ack), 32'd1);
    check("sim_no_iack", 32'(inst_ack), 32'd0);
    check("sim_data_rdata", data_rdata, 32'hCAFEF00D);
    data_req = 1'b0;
    @(negedge clk);
    serve(0, 1'b0, 32'hBFC00004, 32'd0, 32'h11112222);
    check("sim_inst_ack", 32'(inst_ack), 32'd1);
    check("sim_no_dack", 32'(data_ack), 32'd0);
    check("sim_inst_rdata", inst_rdata, 32'h11112222);
    check("sim_data_rdata_hold", data_rdata, 32'hCAFEF00D);
    inst_req = 1'b0;
    @(negedge clk);

    // Fairness: both held, order D,D,D,D,I repeating
    data_req = 1'b1; data_addr = 32'h80004000;
    inst_req = 1'b1; inst_addr = 32'hBFC00008;
    for (int k = 0; k < 10; k++) begin
      logic is_d;
      is_d = ((k % 5) != 4);
      serve(0, 1'b0, is_d ? 32'h80004000 : 32'hBFC00008, 32'd0, 32'(k));
      check("fair_owner_ack", 32'({inst_ack, data_ack}), is_d ? 32'd1 : 32'd2);
    end
    data_req = 1'b0; inst_req = 1'b0;
    @(negedge clk);
    check("fair_idle", 32'(busy), 32'd0);

    // Reset mid-RESP followed by a late rvalid
    data_req = 1'b1; data_addr = 32'h80003000;
    @(negedge clk);
    check("rr_req", 32'(mem_req), 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    check("rr_in_resp", 32'(busy), 32'd1);
    rst = 1'b1; data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555;
    check("rr_mem_req", 32'(mem_req), 32'd0);
    check("rr_mem_addr", mem_addr, 32'd0);
    check("rr_busy", 32'(busy), 32'd0);
    check("rr_inst_rdata", inst_rdata, 32'd0);
    check("rr_data_rdata", data_rdata, 32'd0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("rr_late_acks", 32'({inst_ack, data_ack}), 32'd0);
    check("rr_late_busy", 32'(busy), 32'd0);
    check("rr_late_rdata", data_rdata, 32'd0);
    @(negedge clk);
    check("rr_late_acks2", 32'({inst_ack, data_ack}), 32'd0);
    inst_req = 1'b1; inst_addr = 32'hBFC00010;
    @(negedge clk);
    serve(1, 1'b0, 32'hBFC00010, 32'd0, 32'h55AA55AA);
    check("rr_fresh_ack", 32'(inst_ack), 32'd1);
    check("rr_fresh_rdata", inst_rdata, 32'h55AA55AA);
    inst_req = 1'b0;
    @(negedge clk);
    check("rr_fresh_idle", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
